// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg : shared widths, reset PC and fetch FSM state encoding    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_skid_buf : 2-entry shift FIFO of {instr, pc}; flush wins    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fetch_skid_buf #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [INSTR_W-1:0] head_instr,
  output logic [PC_W-1:0]    head_pc
);

  logic [INSTR_W-1:0] tail_instr;
  logic [PC_W-1:0]    tail_pc;

  // Slot 0 is always the head; it is left untouched when the FIFO empties
  // so the visible head keeps its last value.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count      <= 2'd0;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else begin
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end else begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!clear_n)
    !(push && !pop && !flush && count == 2'd2));

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_fetch_unit : PC register, fetch issue FSM and decode handshake |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module pc_fetch_unit #(
  parameter int PC_W      = cpu_pkg::PC_W,
  parameter int INSTR_W   = cpu_pkg::INSTR_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic               Clk,
  input  logic               Clear,
  output logic [PC_W-1:0]    PC,
  input  logic [PC_W-1:0]    Next_PC,
  input  logic [INSTR_W-1:0] IMem_Data,
  input  logic               Br_Taken,
  input  logic [PC_W-1:0]    Br_Target,
  input  logic               Halt,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    Instr_PC,
  output logic               Instr_Valid,
  input  logic               Instr_Ready,
  output logic               Halted
);

  import cpu_pkg::*;

  localparam logic [2:0] DEPTH_LIMIT = 3'(BUF_DEPTH);

  fetch_state_e    state;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] req_pc;
  logic            req_valid;
  logic [1:0]      count;
  logic [2:0]      credit_use;
  logic            pop;
  logic            push;
  logic            issue;

  // Credit counts buffered entries plus the in-flight response, so a
  // response always has a free slot when it returns.
  assign pop         = Instr_Valid & Instr_Ready;
  assign push        = req_valid & ~Br_Taken;
  assign credit_use  = {1'b0, count} + {2'b00, req_valid} - {2'b00, pop};
  assign issue       = (state == RUN) & ~Br_Taken & ~Halt & (credit_use < DEPTH_LIMIT);
  assign Instr_Valid = (count != 2'd0);
  assign PC          = pc_reg;
  assign Halted      = (state == HALTED);

  always_ff @(posedge Clk) begin
    if (!Clear) begin
      pc_reg    <= PC_W'(RESET_PC);
      req_pc    <= '0;
      req_valid <= 1'b0;
      state     <= RUN;
    end else begin
      req_valid <= issue;
      if (issue) begin
        req_pc <= pc_reg;
        pc_reg <= Next_PC;
      end
      if (Br_Taken) begin
        pc_reg <= Br_Target;
      end
      case (state)
        RUN:     if (Halt) state <= HALTED;
        HALTED:  if (Br_Taken && !Halt) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  fetch_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid_buf (
    .clk        (Clk),
    .clear_n    (Clear),
    .push       (push),
    .push_instr (IMem_Data),
    .push_pc    (req_pc),
    .pop        (pop),
    .flush      (Br_Taken),
    .count      (count),
    .head_instr (Instr),
    .head_pc    (Instr_PC)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_fetch_unit : queue-level reference model plus directed pins |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_pc_fetch_unit;

  logic       Clk = 1'b0;
  logic       Clear, Br_Taken, Halt, Instr_Ready;
  logic [7:0] Br_Target, Next_PC, IMem_Data, PC, Instr, Instr_PC;
  logic       Instr_Valid, Halted;

  always #5 Clk = ~Clk;

  assign Next_PC = PC + 8'd1;
  always @(posedge Clk) IMem_Data <= PC + 8'h10;

  pc_fetch_unit dut (
    .Clk         (Clk),
    .Clear       (Clear),
    .PC          (PC),
    .Next_PC     (Next_PC),
    .IMem_Data   (IMem_Data),
    .Br_Taken    (Br_Taken),
    .Br_Target   (Br_Target),
    .Halt        (Halt),
    .Instr       (Instr),
    .Instr_PC    (Instr_PC),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .Halted      (Halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the decode-visible buffer is a queue of fetch addresses
  // (memory returns addr+0x10), plus at most one outstanding request.
  logic [7:0] q[$];
  logic [7:0] m_pc, m_req_pc, m_last_pc, m_last_instr;
  bit         m_req, m_halted;
  bit         model_live = 1'b0;

  always @(posedge Clk) begin : model
    bit take, fetch;
    if (!Clear) begin
      q.delete();
      m_pc         = 8'h00;
      m_req        = 1'b0;
      m_req_pc     = 8'h00;
      m_halted     = 1'b0;
      m_last_pc    = 8'h00;
      m_last_instr = 8'h00;
      model_live   = 1'b1;
    end else if (model_live) begin
      take  = (q.size() != 0) && Instr_Ready;
      fetch = !m_halted && !Br_Taken && !Halt &&
              (q.size() + int'(m_req) - int'(take) < 2);
      if (take) void'(q.pop_front());
      if (Br_Taken) q.delete();
      else if (m_req) q.push_back(m_req_pc);
      m_req = fetch;
      if (fetch) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 8'd1;
      end
      if (Br_Taken) m_pc = Br_Target;
      m_halted = Halt ? 1'b1 : (Br_Taken ? 1'b0 : m_halted);
      if (q.size() != 0) begin
        m_last_pc    = q[0];
        m_last_instr = q[0] + 8'h10;
      end
    end
  end

  always @(negedge Clk) begin
    if (model_live) begin
      chk("cmp_PC",          PC,          m_pc);
      chk("cmp_Instr_Valid", Instr_Valid, q.size() != 0);
      chk("cmp_Instr_PC",    Instr_PC,    m_last_pc);
      chk("cmp_Instr",       Instr,       m_last_instr);
      chk("cmp_Halted",      Halted,      m_halted);
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},     PC,          8'h00);
    chk({tag, "_valid"},  Instr_Valid, 1'b0);
    chk({tag, "_instr"},  Instr,       8'h00);
    chk({tag, "_ipc"},    Instr_PC,    8'h00);
    chk({tag, "_halted"}, Halted,      1'b0);
  endtask

  logic [7:0] wrap_seq [4];

  initial begin
    wrap_seq    = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    Clear       = 1'b0;
    Br_Taken    = 1'b0;
    Br_Target   = 8'h00;
    Halt        = 1'b0;
    Instr_Ready = 1'b1;
    repeat (2) @(negedge Clk);
    chk_reset_state("reset");

    Clear = 1'b1;
    @(negedge Clk);
    chk("e0_pc",    PC,          8'h01);
    chk("e0_valid", Instr_Valid, 1'b0);
    @(negedge Clk);
    chk("e1_valid", Instr_Valid, 1'b1);
    chk("e1_ipc",   Instr_PC,    8'h00);
    chk("e1_instr", Instr,       8'h10);
    @(negedge Clk);
    chk("stream_ipc", Instr_PC, 8'h01);
    chk("stream_pc",  PC,       8'h03);

    Instr_Ready = 1'b0;
    repeat (5) @(negedge Clk);
    chk("stall_ipc",   Instr_PC,    8'h01);
    chk("stall_valid", Instr_Valid, 1'b1);
    chk("stall_pc",    PC,          8'h03);
    Instr_Ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge Clk);
      chk("resume_ipc", Instr_PC, 32'(k));
    end

    Instr_Ready = 1'b0;
    repeat (3) @(negedge Clk);
    Br_Taken  = 1'b1;
    Br_Target = 8'h40;
    @(negedge Clk);
    Br_Taken    = 1'b0;
    Instr_Ready = 1'b1;
    chk("redir_valid_a", Instr_Valid, 1'b0);
    chk("redir_pc",      PC,          8'h40);
    @(negedge Clk);
    chk("redir_valid_b", Instr_Valid, 1'b0);
    @(negedge Clk);
    chk("redir_valid_c", Instr_Valid, 1'b1);
    chk("redir_ipc",     Instr_PC,    8'h40);
    chk("redir_instr",   Instr,       8'h50);

    Br_Taken  = 1'b1;
    Br_Target = 8'hFE;
    @(negedge Clk);
    Br_Taken = 1'b0;
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("wrap_ipc", Instr_PC, wrap_seq[k]);
    end

    Instr_Ready = 1'b0;
    Halt        = 1'b1;
    @(negedge Clk);
    Halt = 1'b0;
    chk("halt_flag", Halted, 1'b1);
    chk("halt_pc",   PC,     8'h03);
    repeat (3) @(negedge Clk);
    chk("halt_hold_ipc", Instr_PC, 8'h01);
    chk("halt_hold_pc",  PC,       8'h03);
    Instr_Ready = 1'b1;
    repeat (4) @(negedge Clk);
    chk("halt_drained",  Instr_Valid, 1'b0);
    chk("halt_last_ipc", Instr_PC,    8'h02);
    chk("halt_still",    Halted,      1'b1);
    chk("halt_idle_pc",  PC,          8'h03);
    Br_Taken  = 1'b1;
    Br_Target = 8'h20;
    @(negedge Clk);
    Br_Taken = 1'b0;
    chk("unhalt_flag", Halted, 1'b0);
    chk("unhalt_pc",   PC,     8'h20);
    repeat (2) @(negedge Clk);
    chk("unhalt_valid", Instr_Valid, 1'b1);
    chk("unhalt_ipc",   Instr_PC,    8'h20);

    repeat (3) @(negedge Clk);
    Clear = 1'b0;
    @(negedge Clk);
    Clear = 1'b1;
    chk_reset_state("clr");
    repeat (2) @(negedge Clk);
    chk("clr_restart_valid", Instr_Valid, 1'b1);
    chk("clr_restart_ipc",   Instr_PC,    8'h00);

    for (int c = 0; c < 4000; c++) begin
      Instr_Ready = ($urandom_range(0, 9) < 7);
      Br_Taken    = ($urandom_range(0, 19) == 0);
      Br_Target   = 8'($urandom);
      Halt        = ($urandom_range(0, 29) == 0);
      Clear       = ($urandom_range(0, 199) != 0);
      @(negedge Clk);
    end
    Clear    = 1'b1;
    Br_Taken = 1'b0;
    Halt     = 1'b0;
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
